// File: rtl/buzzer_scheduler.sv
// ---------------------------------------------------------------------------
// buzzer_scheduler
//
// Serves up to three alarm channels by driving one buzzer at a time.
// Requests are latched into a pending vector. Whenever the block is idle and
// something is pending, a round-robin arbiter picks one channel. That channel
// buzzes for ON_LEN cycles, and a silent gap of GAP_LEN cycles follows before
// the next grant.
//
// Parameters
//   ON_LEN   : buzz duration in cycles (1..31)
//   GAP_LEN  : silent cycles after each buzz (1..31)
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   req      : per-channel alarm request, level-sampled every cycle
//   mute     : combinationally forces buzz to zero; sequencing is untouched
//   flush    : synchronous clear of all pending requests
//   buzz     : one-hot buzzer drive (registered, gated by ~mute)
//   active   : 1 while a channel is being buzzed
//   grant_id : channel currently served, 2'd3 when not buzzing
//   pending  : latched requests not yet served
// ---------------------------------------------------------------------------
module buzzer_scheduler #(
    parameter int ON_LEN  = 31,
    parameter int GAP_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       mute,
    input  logic       flush,
    output logic [2:0] buzz,
    output logic       active,
    output logic [1:0] grant_id,
    output logic [2:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [4:0] ON_LEN_C  = 5'(ON_LEN);
    localparam logic [4:0] GAP_LEN_C = 5'(GAP_LEN);
    localparam logic [1:0] NO_GRANT  = 2'd3;

    state_t     state,    state_nxt;
    logic [4:0] cnt,      cnt_nxt;
    logic [1:0] last,     last_nxt;
    logic [2:0] pend_q,   pend_nxt;
    logic [2:0] onehot_q, onehot_nxt;
    logic       active_q, active_nxt;
    logic [1:0] gid_q,    gid_nxt;
    logic [1:0] pick;

    // Round-robin search starting one past the last granted channel.
    // Only the latched pending vector is considered. Same-cycle requests
    // wait one edge before they can be granted.
    function automatic logic [1:0] rr_pick(input logic [2:0] pend,
                                           input logic [1:0] prev);
        logic [1:0] sel;
        logic       found;
        sel   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (int'(prev) + k) % 3;
            if (!found && pend[idx]) begin
                sel   = 2'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(pend_q, last);

    // Next-state logic. The registered outputs are computed from the
    // destination state, so active/grant_id/buzz change on the same edge as
    // the state does.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt  = state;
        cnt_nxt    = cnt;
        last_nxt   = last;
        pend_nxt   = pend_q | req;
        onehot_nxt = onehot_q;
        active_nxt = active_q;
        gid_nxt    = gid_q;

        unique case (state)
            S_IDLE: begin
                if (pend_q != 3'b000) begin
                    state_nxt  = S_ON;
                    cnt_nxt    = 5'd1;
                    last_nxt   = pick;
                    onehot_nxt = 3'b001 << pick;
                    active_nxt = 1'b1;
                    gid_nxt    = pick;
                    // Clear the served channel. A request on the grant edge re-sets it.
                    pend_nxt   = (pend_q & ~(3'b001 << pick)) | req;
                end
            end
            S_ON: begin
                if (cnt == ON_LEN_C) begin
                    state_nxt  = S_GAP;
                    cnt_nxt    = 5'd1;
                    onehot_nxt = 3'b000;
                    active_nxt = 1'b0;
                    gid_nxt    = NO_GRANT;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LEN_C) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 5'd0;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                cnt_nxt    = 5'd0;
                onehot_nxt = 3'b000;
                active_nxt = 1'b0;
                gid_nxt    = NO_GRANT;
            end
        endcase

        // flush overrides any same-cycle set, but leaves ON/GAP running.
        if (flush) begin
            pend_nxt = 3'b000;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 5'd0;
            last     <= 2'd2;      // channel 0 is served first after reset
            pend_q   <= 3'b000;
            onehot_q <= 3'b000;
            active_q <= 1'b0;
            gid_q    <= NO_GRANT;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last     <= last_nxt;
            pend_q   <= pend_nxt;
            onehot_q <= onehot_nxt;
            active_q <= active_nxt;
            gid_q    <= gid_nxt;
        end
    end

    assign buzz     = onehot_q & {3{~mute}};
    assign active   = active_q;
    assign grant_id = gid_q;
    assign pending  = pend_q;

endmodule

// File: doc/buzzer_scheduler.md
BUZZER_SCHEDULER -- requirements
Module: buzzer_scheduler

Interface
REQ-001 Parameter ON_LEN, default 31: number of cycles a granted buzzer is driven; legal range 1..31.
REQ-002 Parameter GAP_LEN, default 4: number of silent cycles after each buzz; legal range 1..31.
REQ-003 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req  input  3  alarm request per channel (bit i = sensor channel i), level-sampled every cycle.
REQ-006 Port mute  input  1  when 1, forces buzz to 0 without altering sequencing.
REQ-007 Port flush  input  1  synchronous clear of all pending requests.
REQ-008 Port buzz  output  3  one-hot buzzer drive, or all zero.
REQ-009 Port active  output  1  1 while in state ON.
REQ-010 Port grant_id  output  2  index of the channel being served; 2'd3 when not in ON.
REQ-011 Port pending  output  3  latched, not-yet-served requests.

Function
REQ-012 The block SHALL implement three states: IDLE, ON and GAP.
REQ-013 pending[i] SHALL be set on any edge where req[i]=1, and SHALL stay set until the channel is granted or flushed.
REQ-014 In IDLE with pending!=0, the next edge SHALL enter ON and grant exactly one channel.
REQ-015 Arbitration SHALL be round-robin: the search starts at (last+1) mod 3, where last is the most recently granted channel.
REQ-016 Arbitration SHALL consider only pending, not the same-cycle req; a req arriving in IDLE is therefore granted one cycle later.
REQ-017 On the grant edge, pending[g] SHALL clear, unless req[g]=1 on that edge, in which case it SHALL stay set (set wins).
REQ-018 ON SHALL last exactly ON_LEN cycles.
- buzz = one-hot(g) while mute=0.
- active = 1.
- grant_id = g.
REQ-019 After ON the block SHALL enter GAP for exactly GAP_LEN cycles, with buzz=0, active=0 and grant_id=2'd3.
REQ-020 After GAP the block SHALL return to IDLE; a non-empty pending SHALL be granted on the following edge.
REQ-021 Requests arriving during ON or GAP SHALL be latched into pending and SHALL NOT pre-empt the current grant.
REQ-022 A 5-bit duration counter SHALL load 1 on entering ON or GAP, SHALL increment each cycle, and SHALL exit the state when it equals the length parameter.
REQ-023 The duration counter SHALL never wrap.
REQ-024 flush=1 SHALL clear pending on that edge, overriding same-cycle req sets.
REQ-025 flush SHALL NOT abort an ON or GAP already in progress.
REQ-026 mute SHALL gate buzz combinationally only; state, counter, active and grant_id SHALL be unaffected.
REQ-027 All outputs except buzz SHALL be registered.
REQ-028 buzz SHALL be a registered one-hot ANDed with ~mute.

Reset
REQ-029 Asserting rst SHALL immediately, without waiting for clk, force the following:
- state IDLE;
- pending=0;
- counter=0;
- last=2 (channel 0 is served first);
- buzz=0, active=0, grant_id=2'd3.
REQ-030 rst asserted mid-ON SHALL silence buzz at once, and all requests latched before reset SHALL be lost.
REQ-031 After rst deasserts, the first edge SHALL behave as from IDLE with empty pending.

Verification
REQ-032 Single request (defaults): req=3'b001 for 1 cycle.
- pending=001 one edge later.
- buzz=001 for exactly 31 cycles.
- Then buzz=0 for 4 cycles.
- Then IDLE with pending=0.
REQ-033 Round-robin: req=3'b111 held 1 cycle.
- Grants SHALL occur in order 0, 1, 2.
- Each grant lasts 31 ON + 4 GAP cycles.
- pending SHALL read 110, then 100, then 000.
REQ-034 Rotation continuity: after serving channel 1, req=3'b011 SHALL grant channel 0 next (search starts at 2, channel 2 not pending).
REQ-035 flush: req=100 during ON of channel 0, then flush=1 during GAP.
- pending=000.
- The block SHALL return to IDLE with no further grant.
REQ-036 mute and reset:
- mute=1 during cycles 10-15 of ON SHALL give buzz=000 while active=1 and the ON length stays 31.
- rst pulsed at ON cycle 20 SHALL give buzz=000, grant_id=3 and pending=000 with no clock edge required.
